// File: rtl/mcu_timing_gen.sv
// 8051 machine-cycle timing generator: S1..S6 x P1/P2 ticks, ALE/PSEN, MOVX cycles, hold.
// Optional external-wait stall at t = 5 is enabled by defining TIMING_WAIT_EN.
module mcu_timing_gen #(
  parameter int PHASE_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       movx_req,
`ifdef TIMING_WAIT_EN
  input  logic       ext_ready,
  output logic       wait_active,
`endif
  output logic [2:0] state,
  output logic       phase,
  output logic       clk_6M,
  output logic       clk_1M,
  output logic       ALE,
  output logic       PSEN,
  output logic       mc_start,
  output logic       movx_active
);

  localparam logic [3:0] PRE_LAST = 4'(PHASE_TICKS - 1);

  // START presents t = 0 once after reset before normal prescaled advancing begins
  typedef enum logic [1:0] {
    MODE_START,
    MODE_RUN,
    MODE_WAIT
  } mode_t;

  mode_t      mode, mode_nxt;
  logic [3:0] tick, tick_nxt;
  logic [3:0] pre, pre_nxt;
  logic       movx_nxt;
  logic       start_nxt;
  logic       adv;

  function automatic logic ale_of(input logic [3:0] t, input logic mx);
    logic r;
    r = 1'b0;
    case (t)
      4'd1, 4'd2: r = 1'b1;
      4'd7, 4'd8: r = ~mx;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic psen_of(input logic [3:0] t, input logic mx);
    logic r;
    r = 1'b1;
    case (t)
      4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11: r = mx;
      default:                              r = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    mode_nxt  = mode;
    tick_nxt  = tick;
    pre_nxt   = pre;
    movx_nxt  = movx_active;
    start_nxt = 1'b0;
    adv       = 1'b0;
    if (!hold) begin
      case (mode)
        MODE_START: begin
          mode_nxt  = MODE_RUN;
          tick_nxt  = 4'd0;
          pre_nxt   = 4'd0;
          start_nxt = 1'b1;
        end
        default: begin
          if (pre != PRE_LAST) begin
            pre_nxt = pre + 4'd1;
          end else begin
            pre_nxt = 4'd0;
            adv     = 1'b1;
`ifdef TIMING_WAIT_EN
            if (tick == 4'd5 && !ext_ready) begin
              adv      = 1'b0;
              mode_nxt = MODE_WAIT;
            end else begin
              mode_nxt = MODE_RUN;
            end
`endif
          end
        end
      endcase
      // movx_req only matters on the wrap into the next machine cycle
      if (adv) begin
        if (tick == 4'd11) begin
          tick_nxt  = 4'd0;
          movx_nxt  = movx_req;
          start_nxt = 1'b1;
        end else begin
          tick_nxt = tick + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode        <= MODE_START;
      tick        <= 4'd0;
      pre         <= 4'd0;
      movx_active <= 1'b0;
      mc_start    <= 1'b0;
      state       <= 3'd1;
      phase       <= 1'b0;
      clk_6M      <= 1'b0;
      clk_1M      <= 1'b0;
      ALE         <= 1'b0;
      PSEN        <= 1'b1;
    end else begin
      mode        <= mode_nxt;
      tick        <= tick_nxt;
      pre         <= pre_nxt;
      movx_active <= movx_nxt;
      mc_start    <= start_nxt;
      if (!hold) begin
        state  <= tick_nxt[3:1] + 3'd1;
        phase  <= tick_nxt[0];
        clk_6M <= ~tick_nxt[0];
        clk_1M <= (tick_nxt < 4'd6);
        ALE    <= ale_of(tick_nxt, movx_nxt);
        PSEN   <= psen_of(tick_nxt, movx_nxt);
      end
    end
  end

`ifdef TIMING_WAIT_EN
  assign wait_active = (mode == MODE_WAIT);
`endif

endmodule

// File: tb/tb_mcu_timing_gen.sv
// Scoreboard bench for mcu_timing_gen with PHASE_TICKS = 1 and 3 side by side.
module tb_mcu_timing_gen;

`ifdef TIMING_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, hold, movx_req, ext_ready;
  always #5 clk = ~clk;

  logic [2:0] state_a, state_b;
  logic phase_a, clk6_a, clk1_a, ale_a, psen_a, mc_a, movx_a, wait_a;
  logic phase_b, clk6_b, clk1_b, ale_b, psen_b, mc_b, movx_b, wait_b;

  mcu_timing_gen #(.PHASE_TICKS(1)) dut_a (
    .clk(clk), .reset(reset), .hold(hold), .movx_req(movx_req),
`ifdef TIMING_WAIT_EN
    .ext_ready(ext_ready), .wait_active(wait_a),
`endif
    .state(state_a), .phase(phase_a), .clk_6M(clk6_a), .clk_1M(clk1_a),
    .ALE(ale_a), .PSEN(psen_a), .mc_start(mc_a), .movx_active(movx_a)
  );

  mcu_timing_gen #(.PHASE_TICKS(3)) dut_b (
    .clk(clk), .reset(reset), .hold(hold), .movx_req(movx_req),
`ifdef TIMING_WAIT_EN
    .ext_ready(ext_ready), .wait_active(wait_b),
`endif
    .state(state_b), .phase(phase_b), .clk_6M(clk6_b), .clk_1M(clk1_b),
    .ALE(ale_b), .PSEN(psen_b), .mc_start(mc_b), .movx_active(movx_b)
  );

`ifndef TIMING_WAIT_EN
  assign wait_a = 1'b0;
  assign wait_b = 1'b0;
`endif

  // packed as {state, phase, clk_6M, clk_1M, ALE, PSEN, mc_start, movx_active, wait_active}
  localparam logic [10:0] RESET_OUT = {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef struct {
    bit          started;
    int          tick;
    int          sub;
    bit          movx;
    bit          waiting;
    logic [10:0] out;
  } mdl_t;

  typedef struct packed {
    logic [10:0] a;
    logic [10:0] b;
  } exp_t;

  mdl_t m[2];
  int   pt[2] = '{1, 3};
  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  bit   stim_done = 1'b0;

  function automatic logic [10:0] decode(input int tick, input bit movx, input bit waiting, input bit mc);
    bit ph, ale, psen;
    ph   = (tick % 2) == 1;
    ale  = movx ? (tick inside {1, 2}) : (tick inside {1, 2, 7, 8});
    psen = movx ? 1'b1 : !(tick inside {3, 4, 5, 9, 10, 11});
    return {3'(tick / 2 + 1), ph, !ph, (tick < 6), ale, psen, mc, movx, waiting};
  endfunction

  function automatic void model_step(input int k);
    bit mc;
    mc = 1'b0;
    if (reset) begin
      m[k].started = 1'b0;
      m[k].tick    = 0;
      m[k].sub     = 0;
      m[k].movx    = 1'b0;
      m[k].waiting = 1'b0;
      m[k].out     = RESET_OUT;
    end else if (hold) begin
      m[k].out[2] = 1'b0;
    end else if (!m[k].started) begin
      m[k].started = 1'b1;
      m[k].tick    = 0;
      m[k].sub     = 0;
      m[k].out     = decode(0, m[k].movx, 1'b0, 1'b1);
    end else begin
      m[k].sub = m[k].sub + 1;
      if (m[k].sub == pt[k]) begin
        m[k].sub = 0;
        if (WAIT_EN && m[k].tick == 5 && !ext_ready) begin
          m[k].waiting = 1'b1;
        end else begin
          m[k].waiting = 1'b0;
          m[k].tick = (m[k].tick + 1) % 12;
          if (m[k].tick == 0) begin
            m[k].movx = movx_req;
            mc = 1'b1;
          end
        end
      end
      m[k].out = decode(m[k].tick, m[k].movx, m[k].waiting, mc);
    end
  endfunction

  task automatic apply_stimulus(input bit r, input bit h, input bit mx, input bit rdy);
    exp_t e;
    reset     = r;
    hold      = h;
    movx_req  = mx;
    ext_ready = rdy;
    model_step(0);
    model_step(1);
    e.a = m[0].out;
    e.b = m[1].out;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input exp_t e);
    logic [10:0] act_a, act_b;
    act_a = {state_a, phase_a, clk6_a, clk1_a, ale_a, psen_a, mc_a, movx_a, wait_a};
    act_b = {state_b, phase_b, clk6_b, clk1_b, ale_b, psen_b, mc_b, movx_b, wait_b};
    checks++;
    if (act_a === e.a) passes++;
    else $display("[TB] FAIL pt1_outputs at %0t: got %b expected %b", $time, act_a, e.a);
    checks++;
    if (act_b === e.b) passes++;
    else $display("[TB] FAIL pt3_outputs at %0t: got %b expected %b", $time, act_b, e.b);
  endtask

  task automatic expect_reached(input string name, input bit ok);
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s: target point got 0 required 1", name);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 1);
    for (int i = 0; i < 40; i++) apply_stimulus(0, 0, 0, 1);

    for (int i = 0; i < 40 && m[0].tick != 11; i++) apply_stimulus(0, 0, 0, 1);
    expect_reached("movx_point", m[0].tick == 11);
    apply_stimulus(0, 0, 1, 1);
    for (int i = 0; i < 30; i++) apply_stimulus(0, 0, 0, 1);

    for (int i = 0; i < 40 && m[0].tick != 4; i++) apply_stimulus(0, 0, 0, 1);
    expect_reached("hold_point", m[0].tick == 4);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, 1);
    for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 1);

    for (int i = 0; i < 60 && !(m[0].movx && m[0].tick == 8); i++) apply_stimulus(0, 0, 1, 1);
    expect_reached("movx_reset_point", m[0].movx && m[0].tick == 8);
    apply_stimulus(1, 0, 0, 1);
    for (int i = 0; i < 30; i++) apply_stimulus(0, 0, 0, 1);

`ifdef TIMING_WAIT_EN
    for (int i = 0; i < 40 && m[0].tick != 5; i++) apply_stimulus(0, 0, 0, 1);
    expect_reached("wait_point", m[0].tick == 5);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 1);
`endif

    for (int i = 0; i < 600; i++)
      apply_stimulus($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    stim_done = 1'b1;
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (stim_done) break;
        checks++;
        $display("[TB] FAIL scoreboard_empty at %0t: got 0 entries required 1", $time);
      end else begin
        e = q.pop_front();
        check_output(e);
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
